// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave receive block.
// Register addresses, STATUS/IRQ bit positions, default word width.
package spi_slave_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ADDR_RXDATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_TXDATA   = 2'd3;

    localparam int ST_NEMPTY = 0;
    localparam int ST_DONE   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_ABORT  = 3;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous RX FIFO with first-word-fall-through output.
// A pop frees a slot in the same cycle, so push+pop when full is accepted.
module spi_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: synchronised deserialiser into an RX FIFO, TX shifter,
// and an Avalon-MM register file with a level interrupt.
module spi_slave_rx
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        csn_sync,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int CW = $clog2(DATA_W);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
    logic csn_prev_q, sclk_prev_q;
    logic csn_s, sclk_s, mosi_s;
    logic csn_fall, csn_rise, sclk_rise, sclk_fall;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d, tx_hold_q, tx_hold_d;
    logic              miso_q, miso_d, oe_q, oe_d;
    logic              push, done_set, abort_set, ovf_set;

    logic [3:0]        mask_q, mask_d;
    logic              done_q, done_d, ovf_q, ovf_d, abort_q, abort_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_en, wr_en, pop;
    logic [3:1]        w1c;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_full;
    logic [FW-1:0]     fifo_count;

    logic unused_bits;
    assign unused_bits = ^{writedata[31:DATA_W], tx_q[DATA_W-1]};

    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign csn_fall  = ~csn_s & csn_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign sclk_rise = ~csn_s & sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~csn_s & ~sclk_s & sclk_prev_q;

    assign csn_sync    = csn_s;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign readdata    = rdata_q;
    assign irq = |({abort_q, ovf_q, done_q, ~fifo_empty} & mask_q);

    // Serial side: frame boundaries take priority over clock edges.
    always_comb begin
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        push      = 1'b0;
        done_set  = 1'b0;
        abort_set = 1'b0;
        if (csn_fall) begin
            cnt_d  = '0;
            tx_d   = tx_hold_q;
            miso_d = tx_hold_q[DATA_W-1];
            oe_d   = 1'b1;
        end else if (csn_rise) begin
            cnt_d     = '0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
            done_set  = 1'b1;
            abort_set = (cnt_q != '0);
        end else if (sclk_rise) begin
            rx_d = {rx_q[DATA_W-2:0], mosi_s};
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (sclk_fall) begin
            if (cnt_q == '0) begin
                tx_d   = tx_hold_q;
                miso_d = tx_hold_q[DATA_W-1];
            end else begin
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                miso_d = tx_q[DATA_W-2];
            end
        end
    end

    assign rd_en = chipselect & ~read_n;
    assign wr_en = chipselect & ~write_n;
    assign pop   = rd_en & (address == ADDR_RXDATA) & ~fifo_empty;
    assign ovf_set = push & fifo_full & ~pop;
    assign w1c = (wr_en && address == ADDR_STATUS) ? writedata[3:1] : 3'b0;

    always_comb begin
        done_d    = (done_q & ~w1c[ST_DONE]) | done_set;
        ovf_d     = (ovf_q & ~w1c[ST_OVF]) | ovf_set;
        abort_d   = (abort_q & ~w1c[ST_ABORT]) | abort_set;
        mask_d    = mask_q;
        tx_hold_d = tx_hold_q;
        rdata_d   = rdata_q;
        if (wr_en) begin
            case (address)
                ADDR_IRQ_MASK: mask_d    = writedata[3:0];
                ADDR_TXDATA:   tx_hold_d = writedata[DATA_W-1:0];
                default: ;
            endcase
        end
        if (rd_en) begin
            case (address)
                ADDR_RXDATA:
                    rdata_d = {{(31-DATA_W){1'b0}}, ~fifo_empty,
                               fifo_empty ? {DATA_W{1'b0}} : fifo_dout};
                ADDR_STATUS:
                    rdata_d = {16'b0, 8'(fifo_count), 4'b0,
                               abort_q, ovf_q, done_q, ~fifo_empty};
                ADDR_IRQ_MASK:
                    rdata_d = {28'b0, mask_q};
                default:
                    rdata_d = {{(32-DATA_W){1'b0}}, tx_hold_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            tx_hold_q   <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            mask_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csn_prev_q  <= csn_s;
            sclk_prev_q <= sclk_s;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tx_hold_q   <= tx_hold_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            abort_q     <= abort_d;
            rdata_q     <= rdata_d;
        end
    end

    spi_rx_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({rx_q[DATA_W-2:0], mosi_s}),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: reads queue expectations, a monitor
// compares registered readdata; pin-level outputs are checked directly.
module tb_spi_slave_rx;
    import spi_slave_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        spi_csn = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, csn_sync;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    spi_slave_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_csn     (spi_csn),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .csn_sync    (csn_sync),
        .address     (address),
        .chipselect  (chipselect),
        .read_n      (read_n),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic s;
        exp_t e;
        forever begin
            @(posedge clk);
            s = chipselect & ~read_n & reset_n;
            @(negedge clk);
            if (s) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read got=%h", readdata);
                end else begin
                    e = exp_q.pop_front();
                    if (readdata !== e.exp) begin
                        errors++;
                        $display("FAIL %s got=%h want=%h", e.nm, readdata, e.exp);
                    end
                end
            end
        end
    endtask

    task automatic avm_read(input logic [1:0] a, input logic [31:0] exp,
                            input string nm);
        exp_q.push_back('{nm, exp});
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // One SPI bit period is 8 clk; optionally pop RXDATA exactly when
    // the last bit's word lands in the FIFO.
    task automatic spi_bits(input logic [7:0] b, input int n,
                            input bit pop_last, input logic [31:0] pop_exp,
                            output logic [7:0] cap);
        cap = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            repeat (4) @(negedge clk);
            cap[7-i] = spi_miso;
            spi_sclk = 1'b1;
            if (pop_last && i == n-1) begin
                repeat (2) @(negedge clk);
                avm_read(ADDR_RXDATA, pop_exp, "pop_at_full");
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csn_high();
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] cap;
        fork monitor(); join_none

        #2 reset_n = 1'b0;
        #1;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_miso", {31'b0, spi_miso}, 32'h0);
        chk("rst_oe", {31'b0, spi_miso_oe}, 32'h0);
        chk("rst_csn_sync", {31'b0, csn_sync}, 32'h1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // two-byte frame
        csn_low();
        spi_bits(8'hA5, 8, 1'b0, 32'h0, cap);
        spi_bits(8'h3C, 8, 1'b0, 32'h0, cap);
        csn_high();
        avm_read(ADDR_RXDATA, 32'h1A5, "rx_a5");
        avm_read(ADDR_RXDATA, 32'h13C, "rx_3c");
        avm_read(ADDR_STATUS, 32'h2, "status_done");
        avm_write(ADDR_STATUS, 32'h2);
        avm_read(ADDR_STATUS, 32'h0, "status_w1c");

        // transmit 0x96
        avm_write(ADDR_TXDATA, 32'h96);
        avm_read(ADDR_TXDATA, 32'h96, "txdata_rb");
        chk("oe_idle", {31'b0, spi_miso_oe}, 32'h0);
        csn_low();
        spi_bits(8'h00, 8, 1'b0, 32'h0, cap);
        chk("oe_frame", {31'b0, spi_miso_oe}, 32'h1);
        chk("miso_seq", {24'b0, cap}, 32'h96);
        csn_high();
        chk("oe_after", {31'b0, spi_miso_oe}, 32'h0);
        chk("miso_after", {31'b0, spi_miso}, 32'h0);
        avm_read(ADDR_RXDATA, 32'h100, "rx_00");
        avm_write(ADDR_STATUS, 32'hE);

        // overflow
        csn_low();
        for (int i = 0; i < 17; i++)
            spi_bits(8'h10 + 8'(i), 8, 1'b0, 32'h0, cap);
        csn_high();
        avm_read(ADDR_STATUS, 32'h1007, "status_ovf");
        avm_write(ADDR_IRQ_MASK, 32'h4);
        chk("irq_ovf", {31'b0, irq}, 32'h1);
        avm_write(ADDR_STATUS, 32'h4);
        chk("irq_clr", {31'b0, irq}, 32'h0);
        avm_write(ADDR_STATUS, 32'hE);

        // push and pop in the same cycle while full
        csn_low();
        spi_bits(8'hEE, 8, 1'b1, 32'h110, cap);
        csn_high();
        avm_read(ADDR_STATUS, 32'h1003, "status_pushpop");
        for (int i = 1; i < 16; i++)
            avm_read(ADDR_RXDATA, 32'h110 + 32'(i), "drain");
        avm_read(ADDR_RXDATA, 32'h1EE, "drain_last");
        avm_read(ADDR_RXDATA, 32'h000, "rx_empty");
        avm_read(ADDR_STATUS, 32'h2, "status_empty");
        avm_write(ADDR_STATUS, 32'hE);
        avm_read(ADDR_STATUS, 32'h0, "status_clr");

        // aborted partial word, then a full frame
        csn_low();
        spi_bits(8'hFF, 5, 1'b0, 32'h0, cap);
        csn_high();
        avm_read(ADDR_STATUS, 32'hA, "status_abort");
        avm_write(ADDR_STATUS, 32'hE);
        csn_low();
        spi_bits(8'h55, 8, 1'b0, 32'h0, cap);
        csn_high();
        avm_read(ADDR_RXDATA, 32'h155, "rx_55");
        avm_write(ADDR_STATUS, 32'hE);

        // reset mid-byte
        avm_write(ADDR_IRQ_MASK, 32'h1);
        avm_write(ADDR_TXDATA, 32'hFF);
        avm_read(ADDR_IRQ_MASK, 32'h1, "mask_rb");
        csn_low();
        spi_bits(8'h77, 8, 1'b0, 32'h0, cap);
        chk("irq_nempty", {31'b0, irq}, 32'h1);
        spi_bits(8'h00, 3, 1'b0, 32'h0, cap);
        chk("miso_pre_rst", {31'b0, spi_miso}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_readdata", readdata, 32'h0);
        chk("mid_irq", {31'b0, irq}, 32'h0);
        chk("mid_miso", {31'b0, spi_miso}, 32'h0);
        chk("mid_oe", {31'b0, spi_miso_oe}, 32'h0);
        chk("mid_csn_sync", {31'b0, csn_sync}, 32'h1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("csn_sync_hold", {31'b0, csn_sync}, 32'h1);
        repeat (2) @(posedge clk); #1;
        chk("csn_sync_follow", {31'b0, csn_sync}, 32'h0);
        @(negedge clk);
        csn_high();
        avm_read(ADDR_STATUS, 32'h2, "status_post_rst");
        avm_read(ADDR_IRQ_MASK, 32'h0, "mask_post_rst");

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
